// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types: round-key count, round-key word and
// the key-store state encoding.
package aes_pkg;

   localparam int unsigned AES128_NRK = 11;

   typedef logic [127:0] rkey_t;

   typedef enum logic [1:0] {
      EMPTY,
      LOAD,
      READY,
      PLAY
   } ks_state_e;

endpackage

// File: rtl/aes_key_store_128_if.sv
// Playback request and round-key valid/ready channel between the key store
// (master) and the cipher datapath consuming the keys (slave).
interface aes_key_store_128_if;
   import aes_pkg::*;

   logic       pb_start;
   logic       pb_dir;
   rkey_t      rk;
   logic [3:0] rk_idx;
   logic       rk_vld;
   logic       rk_rdy;
   logic       rk_last;

   modport master (
      input  pb_start, pb_dir, rk_rdy,
      output rk, rk_idx, rk_vld, rk_last
   );

   modport slave (
      output pb_start, pb_dir, rk_rdy,
      input  rk, rk_idx, rk_vld, rk_last
   );

endinterface

// File: rtl/aes_key_store_128.sv
// Captures the 11 round keys streamed by the AES-128 key expander after kld and
// replays them forward or reverse over a valid/ready channel.
module aes_key_store_128
   import aes_pkg::*;
#(
   parameter int unsigned NRK = AES128_NRK
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                kld,
   input  logic [31:0]         wi_0,
   input  logic [31:0]         wi_1,
   input  logic [31:0]         wi_2,
   input  logic [31:0]         wi_3,
   output logic                kvld,
   output logic                busy,
   aes_key_store_128_if.master pb
);

   localparam logic [3:0] LAST_IDX = 4'(NRK - 1);

   ks_state_e  r_state;
   logic [3:0] r_cnt;
   logic [3:0] r_idx;
   logic       r_dir;
   logic       r_kvld;
   logic       r_busy;
   logic       r_vld;
   logic       r_last;
   rkey_t      r_rk;
   rkey_t      r_kmem [NRK];

   logic       w_wr_en;
   logic       w_hs;
   logic [3:0] w_first_idx;
   logic [3:0] w_next_idx;
   logic [3:0] w_end_idx;

   assign w_wr_en     = (r_state == LOAD) && !kld;
   assign w_hs        = r_vld && pb.rk_rdy;
   assign w_first_idx = pb.pb_dir ? LAST_IDX : 4'd0;
   assign w_next_idx  = r_dir ? (r_idx - 4'd1) : (r_idx + 4'd1);
   assign w_end_idx   = r_dir ? 4'd0 : LAST_IDX;

   // Key memory is deliberately left out of reset; kvld guards its contents.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_kmem[r_cnt] <= {wi_0, wi_1, wi_2, wi_3};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= EMPTY;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_dir   <= 1'b0;
         r_kvld  <= 1'b0;
         r_busy  <= 1'b0;
         r_vld   <= 1'b0;
         r_last  <= 1'b0;
         r_rk    <= '0;
      end else if (kld) begin
         r_state <= LOAD;
         r_cnt   <= '0;
         r_kvld  <= 1'b0;
         r_busy  <= 1'b1;
         r_vld   <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         case (r_state)
            LOAD: begin
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == LAST_IDX) begin
                  r_state <= READY;
                  r_cnt   <= '0;
                  r_kvld  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            READY: begin
               if (pb.pb_start) begin
                  r_state <= PLAY;
                  r_dir   <= pb.pb_dir;
                  r_idx   <= w_first_idx;
                  r_rk    <= r_kmem[w_first_idx];
                  r_vld   <= 1'b1;
                  r_last  <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            PLAY: begin
               if (w_hs) begin
                  if (r_last) begin
                     r_state <= READY;
                     r_vld   <= 1'b0;
                     r_last  <= 1'b0;
                     r_busy  <= 1'b0;
                  end else begin
                     r_idx  <= w_next_idx;
                     r_rk   <= r_kmem[w_next_idx];
                     r_last <= (w_next_idx == w_end_idx);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign kvld       = r_kvld;
   assign busy       = r_busy;
   assign pb.rk      = r_rk;
   assign pb.rk_idx  = r_idx;
   assign pb.rk_vld  = r_vld;
   assign pb.rk_last = r_last;

endmodule

// File: doc/aes_key_store_128.md
# aes_key_store_128

Round-key store placed directly downstream of the AES-128 key expander. It captures the 11 round keys the expander emits on consecutive cycles after a key load. It then replays them on request, forward (round 0→10) for encryption or reverse (round 10→0) for the inverse cipher, using a valid/ready handshake. This gives the decryption datapath the last round key first without re-running the expansion backwards.

## Interface
Parameters:
- `NRK`, 11: number of round keys stored (AES-128: Nr+1).

Ports:
- `clk`  in  1  Rising-edge clock; the only clock.
- `rst`  in  1  Asynchronous, active-low reset.
- `kld`  in  1  Key load strobe. The same signal drives the expander's `kld`.
- `wi_0`..`wi_3`  in  32 each  Expander outputs `wo_0`..`wo_3`. `wi_0` is the most significant word.
- `kvld`  out  1  All 11 round keys captured and valid.
- `busy`  out  1  State is LOAD or PLAY.
- `pb_start`  in  1  Start a playback. Honoured only in READY.
- `pb_dir`  in  1  Direction, sampled with `pb_start`: 0 = round 0→10, 1 = round 10→0.
- `rk`  out  128  Current round key, `{w0,w1,w2,w3}`.
- `rk_idx`  out  4  Round number of `rk`.
- `rk_vld`  out  1  `rk` is valid.
- `rk_rdy`  in  1  Consumer accepts `rk` on an edge where `rk_vld && rk_rdy`.
- `rk_last`  out  1  `rk` is the final key of this playback.

## Operation
- States: EMPTY (reset), LOAD, READY, PLAY.
- **kld, any state:**
  - Go to LOAD with the capture counter `cnt` = 0.
  - Clear `kvld`, `rk_vld` and `rk_last`; any playback is aborted.
  - A `kld` held for several cycles restarts the load on every cycle it is high.
- **LOAD:**
  - Each cycle with `kld` low: `kmem[cnt] <= {wi_0,wi_1,wi_2,wi_3}`, `cnt++`.
  - After the write at `cnt` = NRK-1, go to READY and set `kvld` = 1.
- **READY:**
  - If `pb_start` is high, latch `pb_dir` and go to PLAY.
  - Load the first key: index 0 if `pb_dir` = 0, index 10 if `pb_dir` = 1.
  - `rk_vld` = 1 and `rk_last` = 0 (NRK > 1).
- **EMPTY:** `pb_start` is ignored.
- **PLAY:**
  - On handshake (`rk_vld && rk_rdy`) with `rk_last` = 0: step the index by ±1 and present the next key.
  - `rk_last` = 1 when the index is 10 (forward) or 0 (reverse).
  - Handshake on the last key: `rk_vld` = 0, `rk_last` = 0, go to READY.
  - `rk` and `rk_idx` hold their value while `rk_vld && !rk_rdy`.
- **Simultaneous events:**
  - `kld` has priority over `pb_start` and over a handshake.
  - `pb_start` in PLAY or LOAD is ignored.
- **rst low (asynchronous):**
  - State goes to EMPTY, `cnt` = 0.
  - Outputs: `kvld` = 0, `busy` = 0, `rk` = 0, `rk_idx` = 0, `rk_vld` = 0, `rk_last` = 0.
  - `kmem` is not reset.
- `busy` is registered: high in LOAD and PLAY.

## Timing
- **Expander alignment:** with `kld` sampled high at edge E0, the expander shows round r on `wi` during the cycle after edge E0+r. The store writes round r at edge E0+r+1.
- **Load latency:** `kvld` rises after edge E0+11, provided `kld` is low from E0+1 onward.
- **Start latency:** `pb_start` sampled at edge P → `rk_vld` and the first `rk` are visible after P. There is no combinational path from `pb_start` to `rk`.
- **Throughput:** one key per cycle with `rk_rdy` held high. A full playback spans edges P..P+11.
- **Output registers:** all outputs are registered. `rk_rdy` affects only next-state logic.

## Structure
- Shared `aes_pkg` holds:
  - `AES128_NRK` = 11;
  - typedef `rkey_t` = `logic [127:0]`;
  - enum `ks_state_e` {EMPTY, LOAD, READY, PLAY}.
- Single module, no sub-module. `kmem` is a 11×128 flop array: write port indexed by `cnt`, read port indexed by a 4-bit playback pointer.

## Test plan
- **Forward playback:**
  - Stimulus: expander plus store; `kld` with key `2b7e151628aed2a6abf7158809cf4f3c`; then `pb_start` with `pb_dir` = 0 and `rk_rdy` = 1.
  - Required: `kvld` high 11 cycles after `kld`. 11 keys appear on consecutive cycles: first = the input key, idx 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6` with `rk_last` = 1.
- **Reverse playback:**
  - Stimulus: same key, `pb_dir` = 1.
  - Required: first `rk` = `d014f9a8…0ca6` at idx 10; last = `2b7e1516…4f3c` at idx 0 with `rk_last` = 1.
- **Backpressure:**
  - Stimulus: toggle `rk_rdy` randomly during playback.
  - Required: `rk` and `rk_idx` stable while stalled. Sequence intact, no key skipped or duplicated.
- **Reload abort:**
  - Stimulus: `kld` with key `000102030405060708090a0b0c0d0e0f` asserted mid-PLAY.
  - Required: next cycle `rk_vld` = 0 and `kvld` = 0. 11 cycles later a forward playback ends at `13111d7fe3944a17f307a78b4d2b30c5`.
- **Ignored requests:**
  - Stimulus: `pb_start` while in EMPTY and during LOAD.
  - Required: `rk_vld` stays 0. A `pb_start` and `kld` in the same cycle → LOAD wins.
- **Asynchronous reset:**
  - Stimulus: drop `rst` between clock edges mid-PLAY.
  - Required: every output is 0 immediately. After release, `pb_start` is ignored until a new load completes.
